mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Memory controller that arbitrates between the IF stage (instruction fetch) and the MEM stage (load/store).
- Serialises each 1/2/4-byte access onto the byte-wide single-port RAM bus.
- Returns assembled read data, or write completion, to the requester with a one-cycle done pulse.
- Sits between the MEM/IF stages and the RAM. It is the consumer of MEM's MCE/MCrw/MCAddr/MCData/MCLen requests.

Parameters:
- ADDR_WIDTH, 32, width of request and RAM addresses.
- MEM_PRIORITY, 1, 1 = MEM wins a simultaneous request in IDLE; 0 = IF wins.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  synchronous active-high reset.
- IF_MCE_in  input  1  IF fetch request (always 4 bytes, read).
- IF_addr_in  input  ADDR_WIDTH  fetch address.
- IF_abort_in  input  1  IF cancels its fetch (branch flush).
- MEM_MCE_in  input  1  MEM request.
- MEM_rw_in  input  1  0 = read, 1 = write.
- MEM_addr_in  input  ADDR_WIDTH  MEM address.
- MEM_data_in  input  32  store data, low bytes used.
- MEM_len_in  input  3  byte count: 1, 2 or 4.
- ram_din_in  input  8  byte read from RAM.
- ram_a_out  output  ADDR_WIDTH  RAM byte address.
- ram_dout_out  output  8  RAM write byte.
- ram_wr_out  output  1  RAM write strobe.
- MC_busyIF_out  output  1  controller serving IF.
- MC_busyMEM_out  output  1  controller serving MEM.
- MC_dataE_out  output  1  one-cycle MEM completion pulse.
- MC_data_out  output  32  MEM load data, zero-extended.
- IF_dataE_out  output  1  one-cycle fetch completion pulse.
- IF_data_out  output  32  fetched instruction.

Behaviour:

Reset:
- rst_in sampled high → state IDLE, counters 0, data buffer 0.
- All outputs 0. ram_wr_out is 0 in the cycle after the reset edge.
- Reset mid-transaction aborts it. No done pulse is produced; a partially written store is left as is.

States: IDLE, READ, WRITE, DONE. Registers hold owner (IF/MEM), address, length N, count k, and a 32-bit buffer.

Accept (IDLE only):
- A request is valid if:
  - IF_MCE_in=1 and IF_abort_in=0, or
  - MEM_MCE_in=1 and MEM_len_in is in {1, 2, 4}.
- Invalid lengths are ignored.
- Both valid → MEM_PRIORITY decides.
- Winner is latched at the edge; next state is READ (IF, or MEM with rw=0) or WRITE.
- The loser is not queued. It must hold its request, and is served next IDLE.

READ, N bytes; cycles numbered 1.. after the accept edge:
- Cycle i, for 1≤i≤N: ram_a_out = addr+i-1 (mod 2^ADDR_WIDTH), ram_wr_out = 0.
- RAM has 1-cycle read latency: the byte for addr+j is on ram_din_in in cycle j+2.
- That byte is captured into buffer[8j+7:8j] at the end of cycle j+2.
- After the last capture (end of cycle N+1) → DONE.
- ram_a_out = 0 in cycle N+1.
- Total: accept edge to done pulse is N+2 cycles.

WRITE:
- Cycle i, for 1≤i≤N: ram_a_out = addr+i-1, ram_dout_out = MEM_data_in byte i-1 (latched copy), ram_wr_out = 1.
- After cycle N → DONE.

DONE:
- Exactly one cycle.
- Owner MEM → MC_dataE_out = 1. For a read, MC_data_out = buffer with bytes ≥N zero.
- Owner IF → IF_dataE_out = 1, IF_data_out = buffer.
- Next state IDLE. No request is accepted in DONE.

Data outputs outside DONE:
- MC_data_out / IF_data_out are 0 outside DONE.
- The dataE pulses are never asserted outside DONE.

Busy flags:
- MC_busyIF_out = 1 in READ/DONE when owner is IF.
- MC_busyMEM_out = 1 in READ/WRITE/DONE when owner is MEM.
- Both are 0 in IDLE.

IF abort:
- IF_abort_in=1 in a READ or DONE cycle owned by IF → IF_dataE_out forced 0 that cycle, next state IDLE.
- In IDLE, IF_abort_in=1 blocks IF acceptance.
- Abort has no effect on MEM transactions.

Writes are never aborted except by reset. Address increment wraps silently.

Test Plan:
1. Load word: MEM read addr 0x100, len 4; RAM bytes 0x11, 0x22, 0x33, 0x44 → ram_a_out 0x100..0x103 on cycles 1-4; MC_dataE_out=1 on cycle 6 with MC_data_out=0x44332211; MC_busyMEM_out high cycles 1-6.
2. Store half: MEM write addr 0x20, data 0xDEADBEEF, len 2 → cycle 1 (0x20, 0xEF, wr=1), cycle 2 (0x21, 0xBE, wr=1); MC_dataE_out=1 cycle 3; RAM 0x22 untouched.
3. Simultaneous IF (0x0) and MEM LB (0x40), MEM_PRIORITY=1 → MEM served first (MC_data_out=byte, upper 24 bits 0); IF accepted on the IDLE cycle after DONE, IF_dataE_out 6 cycles later.
4. IF fetch at 0x1000, IF_abort_in pulsed in cycle 3 → no IF_dataE_out; MC_busyIF_out low from cycle 4; a fresh fetch at 0x2000 returns the correct word.
5. Reset asserted during cycle 2 of a 4-byte write → all outputs 0 next cycle, state IDLE, no MC_dataE_out; the following request completes normally.
6. Wrap: MEM read addr 0xFFFFFFFE, len 4 → ram_a_out FFFFFFFE, FFFFFFFF, 00000000, 00000001; MEM_len_in=3 in IDLE → ignored, busy flags stay 0.

Source files
------------

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates instruction fetch (IF) and load/store (MEM) requests onto a
// byte-wide single-port RAM. Each accepted 1/2/4-byte access is serialised one byte
// per cycle. The requester gets a one-cycle done pulse, with read data assembled
// little-endian.
module mem_ctrl #(
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_PRIORITY = 1
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  IF_MCE_in,
    input  logic [ADDR_WIDTH-1:0] IF_addr_in,
    input  logic                  IF_abort_in,
    input  logic                  MEM_MCE_in,
    input  logic                  MEM_rw_in,
    input  logic [ADDR_WIDTH-1:0] MEM_addr_in,
    input  logic [31:0]           MEM_data_in,
    input  logic [2:0]            MEM_len_in,
    input  logic [7:0]            ram_din_in,
    output logic [ADDR_WIDTH-1:0] ram_a_out,
    output logic [7:0]            ram_dout_out,
    output logic                  ram_wr_out,
    output logic                  MC_busyIF_out,
    output logic                  MC_busyMEM_out,
    output logic                  MC_dataE_out,
    output logic [31:0]           MC_data_out,
    output logic                  IF_dataE_out,
    output logic [31:0]           IF_data_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic                  r_ownerMem;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_len;
    logic [2:0]            r_cnt;
    logic [31:0]           r_buf;
    logic [31:0]           r_wdata;

    logic [ADDR_WIDTH-1:0] r_ramA;
    logic [7:0]            r_ramDout;
    logic                  r_ramWr;
    logic                  r_busyIf;
    logic                  r_busyMem;
    logic                  r_mcDataE;
    logic [31:0]           r_mcData;
    logic                  r_ifDataE;
    logic [31:0]           r_ifData;

    logic                  w_ifValid;
    logic                  w_memValid;
    logic                  w_pickMem;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_reqAddr;
    logic [2:0]            w_reqLen;
    logic                  w_reqWrite;
    logic                  w_lastRead;
    logic                  w_abortIf;
    logic [ADDR_WIDTH-1:0] w_nextAddr;
    logic [7:0]            w_wrByte;
    logic [31:0]           w_bufNext;

    // Request qualification and arbitration; only meaningful while idle.
    always_comb begin
        w_ifValid  = IF_MCE_in & ~IF_abort_in;
        w_memValid = MEM_MCE_in & ((MEM_len_in == 3'd1) || (MEM_len_in == 3'd2) || (MEM_len_in == 3'd4));
        w_pickMem  = w_memValid & (~w_ifValid | (MEM_PRIORITY != 0));
        w_accept   = w_ifValid | w_memValid;
        w_reqAddr  = w_pickMem ? MEM_addr_in : IF_addr_in;
        w_reqLen   = w_pickMem ? MEM_len_in : 3'd4;
        w_reqWrite = w_pickMem & MEM_rw_in;
        w_lastRead = (r_cnt == r_len + 3'd1);
        w_abortIf  = IF_abort_in & ~r_ownerMem;
        w_nextAddr = r_addr + ADDR_WIDTH'(r_cnt);
        w_wrByte   = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
    end

    // Read bytes arrive one cycle after their address, so cycle k captures byte k-2.
    always_comb begin
        w_bufNext = r_buf;
        if (r_state == S_READ) begin
            case (r_cnt)
                3'd2:    w_bufNext[7:0]   = ram_din_in;
                3'd3:    w_bufNext[15:8]  = ram_din_in;
                3'd4:    w_bufNext[23:16] = ram_din_in;
                3'd5:    w_bufNext[31:24] = ram_din_in;
                default: w_bufNext = r_buf;
            endcase
        end
    end

    // Main FSM; every output is registered for the state being entered.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= S_IDLE;
            r_ownerMem <= 1'b0;
            r_addr     <= '0;
            r_len      <= 3'd0;
            r_cnt      <= 3'd0;
            r_buf      <= 32'd0;
            r_wdata    <= 32'd0;
            r_ramA     <= '0;
            r_ramDout  <= 8'd0;
            r_ramWr    <= 1'b0;
            r_busyIf   <= 1'b0;
            r_busyMem  <= 1'b0;
            r_mcDataE  <= 1'b0;
            r_mcData   <= 32'd0;
            r_ifDataE  <= 1'b0;
            r_ifData   <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ownerMem <= w_pickMem;
                        r_addr     <= w_reqAddr;
                        r_len      <= w_reqLen;
                        r_wdata    <= MEM_data_in;
                        r_buf      <= 32'd0;
                        r_cnt      <= 3'd1;
                        r_ramA     <= w_reqAddr;
                        r_busyMem  <= w_pickMem;
                        r_busyIf   <= ~w_pickMem;
                        if (w_reqWrite) begin
                            r_state   <= S_WRITE;
                            r_ramWr   <= 1'b1;
                            r_ramDout <= MEM_data_in[7:0];
                        end else begin
                            r_state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (w_abortIf) begin
                        r_state  <= S_IDLE;
                        r_ramA   <= '0;
                        r_busyIf <= 1'b0;
                    end else begin
                        r_buf <= w_bufNext;
                        r_cnt <= r_cnt + 3'd1;
                        if (w_lastRead) begin
                            r_state <= S_DONE;
                            r_ramA  <= '0;
                            if (r_ownerMem) begin
                                r_mcDataE <= 1'b1;
                                r_mcData  <= w_bufNext;
                            end else begin
                                r_ifDataE <= 1'b1;
                                r_ifData  <= w_bufNext;
                            end
                        end else if (r_cnt < r_len) begin
                            r_ramA <= w_nextAddr;
                        end else begin
                            r_ramA <= '0;
                        end
                    end
                end
                S_WRITE: begin
                    if (r_cnt == r_len) begin
                        r_state   <= S_DONE;
                        r_ramWr   <= 1'b0;
                        r_ramA    <= '0;
                        r_ramDout <= 8'd0;
                        r_mcDataE <= 1'b1;
                    end else begin
                        r_ramA    <= w_nextAddr;
                        r_ramDout <= w_wrByte;
                        r_cnt     <= r_cnt + 3'd1;
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_ramA    <= '0;
                    r_busyIf  <= 1'b0;
                    r_busyMem <= 1'b0;
                    r_mcDataE <= 1'b0;
                    r_mcData  <= 32'd0;
                    r_ifDataE <= 1'b0;
                    r_ifData  <= 32'd0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A late IF abort must suppress the fetch pulse in the very cycle it appears.
    always_comb begin
        ram_a_out      = r_ramA;
        ram_dout_out   = r_ramDout;
        ram_wr_out     = r_ramWr;
        MC_busyIF_out  = r_busyIf;
        MC_busyMEM_out = r_busyMem;
        MC_dataE_out   = r_mcDataE;
        MC_data_out    = r_mcData;
        IF_dataE_out   = r_ifDataE & ~IF_abort_in;
        IF_data_out    = r_ifData;
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: drives mem_ctrl against a byte-wide RAM model with one-cycle read
// latency; expected completions are queued when requests are issued and popped
// when a done pulse appears.
module tb_mem_ctrl;

    typedef struct {
        bit          isMem;
        bit          chk;
        logic [31:0] data;
    } sbEntry_t;

    logic        clk;
    logic        rst;
    logic        ifMce;
    logic [31:0] ifAddr;
    logic        ifAbort;
    logic        memMce;
    logic        memRw;
    logic [31:0] memAddr;
    logic [31:0] memData;
    logic [2:0]  memLen;
    logic [7:0]  ramDin;
    logic [31:0] ramA;
    logic [7:0]  ramDout;
    logic        ramWr;
    logic        busyIf;
    logic        busyMem;
    logic        mcDataE;
    logic [31:0] mcData;
    logic        ifDataE;
    logic [31:0] ifData;

    logic [7:0]  mem [65536];
    logic        pokeEn;
    logic [15:0] pokeAddr;
    logic [7:0]  pokeData;

    sbEntry_t    sb [$];
    sbEntry_t    sbExp;
    int          checks;
    int          errors;

    mem_ctrl #(.ADDR_WIDTH(32), .MEM_PRIORITY(1)) dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .IF_MCE_in     (ifMce),
        .IF_addr_in    (ifAddr),
        .IF_abort_in   (ifAbort),
        .MEM_MCE_in    (memMce),
        .MEM_rw_in     (memRw),
        .MEM_addr_in   (memAddr),
        .MEM_data_in   (memData),
        .MEM_len_in    (memLen),
        .ram_din_in    (ramDin),
        .ram_a_out     (ramA),
        .ram_dout_out  (ramDout),
        .ram_wr_out    (ramWr),
        .MC_busyIF_out (busyIf),
        .MC_busyMEM_out(busyMem),
        .MC_dataE_out  (mcDataE),
        .MC_data_out   (mcData),
        .IF_dataE_out  (ifDataE),
        .IF_data_out   (ifData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: synchronous read (data one cycle after address), write strobe, bench poke port.
    always @(posedge clk) begin
        ramDin <= mem[ramA[15:0]];
        if (ramWr) mem[ramA[15:0]] <= ramDout;
        else if (pokeEn) mem[pokeAddr] <= pokeData;
    end

    // Scoreboard: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && (mcDataE || ifDataE)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected mcDataE=%0b ifDataE=%0b, required no pulse", mcDataE, ifDataE);
            end else begin
                sbExp = sb.pop_front();
                if (mcDataE !== sbExp.isMem || ifDataE !== !sbExp.isMem ||
                    (sbExp.chk && ((sbExp.isMem ? mcData : ifData) !== sbExp.data))) begin
                    errors++;
                    $display("[TB] FAIL sb_done mcDataE=%0b ifDataE=%0b mcData=%h ifData=%h, required isMem=%0b data=%h",
                             mcDataE, ifDataE, mcData, ifData, sbExp.isMem, sbExp.data);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic poke(input logic [31:0] addr, input logic [7:0] data);
        pokeAddr = addr[15:0];
        pokeData = data;
        pokeEn   = 1'b1;
        nextCycle();
        pokeEn   = 1'b0;
    endtask

    task automatic poke4(input logic [31:0] addr, input logic [31:0] word);
        for (int b = 0; b < 4; b++) poke(addr + 32'(b), word[8*b +: 8]);
    endtask

    task automatic startMem(input logic rw, input logic [31:0] addr, input logic [31:0] data, input logic [2:0] len);
        memMce  = 1'b1;
        memRw   = rw;
        memAddr = addr;
        memData = data;
        memLen  = len;
        nextCycle();
        memMce  = 1'b0;
    endtask

    task automatic startIf(input logic [31:0] addr);
        ifMce  = 1'b1;
        ifAddr = addr;
        nextCycle();
        ifMce  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checks++;
        if ({ramA, ramDout, ramWr, busyIf, busyMem, mcDataE, mcData, ifDataE, ifData} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs a=%h dout=%h wr=%0b bIf=%0b bMem=%0b, required all 0", ramA, ramDout, ramWr, busyIf, busyMem);
        end
        nextCycle();
        rst = 1'b0;
        nextCycle();
    endtask

    task automatic test_load_word();
        logic [31:0] expA;
        poke4(32'h100, 32'h44332211);
        sb.push_back('{isMem: 1'b1, chk: 1'b1, data: 32'h44332211});
        startMem(1'b0, 32'h100, 32'h0, 3'd4);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            expA = (c <= 4) ? 32'h100 + 32'(c - 1) : 32'h0;
            checks++;
            if (c <= 5 && (ramA !== expA || ramWr !== 1'b0)) begin
                errors++;
                $display("[TB] FAIL load_addr c=%0d a=%h wr=%0b, required a=%h wr=0", c, ramA, ramWr, expA);
            end
            checks++;
            if (busyMem !== (c <= 6) || mcDataE !== (c == 6)) begin
                errors++;
                $display("[TB] FAIL load_timing c=%0d busyMem=%0b dataE=%0b, required %0b %0b", c, busyMem, mcDataE, c <= 6, c == 6);
            end
            nextCycle();
        end
    endtask

    task automatic test_store_half();
        logic [31:0] expA;
        logic [7:0]  expD;
        poke(32'h20, 8'h00);
        poke(32'h21, 8'h00);
        poke(32'h22, 8'h5A);
        sb.push_back('{isMem: 1'b1, chk: 1'b0, data: 32'h0});
        startMem(1'b1, 32'h20, 32'hDEADBEEF, 3'd2);
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            expA = (c == 1) ? 32'h20 : 32'h21;
            expD = (c == 1) ? 8'hEF : 8'hBE;
            checks++;
            if (ramWr !== (c <= 2) || (c <= 2 && (ramA !== expA || ramDout !== expD))) begin
                errors++;
                $display("[TB] FAIL store_bus c=%0d a=%h dout=%h wr=%0b, required a=%h dout=%h wr=%0b", c, ramA, ramDout, ramWr, expA, expD, c <= 2);
            end
            checks++;
            if (busyMem !== (c <= 3) || mcDataE !== (c == 3)) begin
                errors++;
                $display("[TB] FAIL store_timing c=%0d busyMem=%0b dataE=%0b, required %0b %0b", c, busyMem, mcDataE, c <= 3, c == 3);
            end
            nextCycle();
        end
        checks++;
        if ({mem[16'h20], mem[16'h21], mem[16'h22]} !== {8'hEF, 8'hBE, 8'h5A}) begin
            errors++;
            $display("[TB] FAIL store_ram got %h %h %h, required EF BE 5A", mem[16'h20], mem[16'h21], mem[16'h22]);
        end
    endtask

    task automatic test_simultaneous();
        logic [31:0] expA;
        logic        chkA;
        poke(32'h40, 8'hA7);
        poke4(32'h0, 32'h04030201);
        sb.push_back('{isMem: 1'b1, chk: 1'b1, data: 32'h000000A7});
        sb.push_back('{isMem: 1'b0, chk: 1'b1, data: 32'h04030201});
        ifMce  = 1'b1;
        ifAddr = 32'h0;
        startMem(1'b0, 32'h40, 32'h0, 3'd1);
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            chkA = 1'b1;
            case (c)
                1:       expA = 32'h40;
                2:       expA = 32'h0;
                5, 6, 7, 8: expA = 32'(c - 5);
                9:       expA = 32'h0;
                default: begin expA = 32'h0; chkA = 1'b0; end
            endcase
            checks++;
            if (chkA && ramA !== expA) begin
                errors++;
                $display("[TB] FAIL simul_addr c=%0d a=%h, required %h", c, ramA, expA);
            end
            checks++;
            if (busyMem !== (c <= 3) || busyIf !== (c >= 5 && c <= 10) || mcDataE !== (c == 3) || ifDataE !== (c == 10)) begin
                errors++;
                $display("[TB] FAIL simul_timing c=%0d bMem=%0b bIf=%0b mcE=%0b ifE=%0b", c, busyMem, busyIf, mcDataE, ifDataE);
            end
            nextCycle();
            if (c == 4) ifMce = 1'b0;
        end
    endtask

    task automatic test_abort();
        int doneAt;
        poke4(32'h1000, 32'h9ABCDEF0);
        poke4(32'h2000, 32'h12345678);
        startIf(32'h1000);
        for (int c = 1; c <= 8; c++) begin
            if (c == 3) ifAbort = 1'b1;
            @(negedge clk);
            checks++;
            if (busyIf !== (c <= 3) || ifDataE !== 1'b0 || (c <= 3 && ramA !== 32'h1000 + 32'(c - 1))) begin
                errors++;
                $display("[TB] FAIL abort_cycle c=%0d bIf=%0b ifE=%0b a=%h, required bIf=%0b ifE=0", c, busyIf, ifDataE, ramA, c <= 3);
            end
            nextCycle();
            ifAbort = 1'b0;
        end
        sb.push_back('{isMem: 1'b0, chk: 1'b1, data: 32'h12345678});
        doneAt = 0;
        startIf(32'h2000);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (doneAt == 0 && ifDataE) doneAt = c;
            nextCycle();
        end
        checks++;
        if (doneAt != 6) begin
            errors++;
            $display("[TB] FAIL abort_refetch done cycle=%0d, required 6", doneAt);
        end
    endtask

    task automatic test_reset_mid_write();
        int doneAt;
        poke4(32'h300, 32'h0);
        startMem(1'b1, 32'h300, 32'hCAFEF00D, 3'd4);
        @(negedge clk);
        checks++;
        if ({ramA, ramDout, ramWr} !== {32'h300, 8'h0D, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rstw_c1 a=%h dout=%h wr=%0b, required 300 0D 1", ramA, ramDout, ramWr);
        end
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({ramA, ramDout, ramWr} !== {32'h301, 8'hF0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL rstw_c2 a=%h dout=%h wr=%0b, required 301 F0 1", ramA, ramDout, ramWr);
        end
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({ramA, ramDout, ramWr, busyIf, busyMem, mcDataE, mcData, ifDataE, ifData} !== '0) begin
            errors++;
            $display("[TB] FAIL rstw_outputs a=%h wr=%0b bMem=%0b mcE=%0b, required all 0", ramA, ramWr, busyMem, mcDataE);
        end
        for (int c = 0; c < 3; c++) begin
            nextCycle();
            @(negedge clk);
            checks++;
            if (mcDataE !== 1'b0 || busyMem !== 1'b0) begin
                errors++;
                $display("[TB] FAIL rstw_idle mcE=%0b bMem=%0b, required 0 0", mcDataE, busyMem);
            end
        end
        nextCycle();
        checks++;
        if ({mem[16'h300], mem[16'h301], mem[16'h302], mem[16'h303]} !== {8'h0D, 8'hF0, 8'h00, 8'h00}) begin
            errors++;
            $display("[TB] FAIL rstw_ram got %h %h %h %h, required 0D F0 00 00", mem[16'h300], mem[16'h301], mem[16'h302], mem[16'h303]);
        end
        sb.push_back('{isMem: 1'b1, chk: 1'b1, data: 32'h0000F00D});
        doneAt = 0;
        startMem(1'b0, 32'h300, 32'h0, 3'd2);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (doneAt == 0 && mcDataE) doneAt = c;
            nextCycle();
        end
        checks++;
        if (doneAt != 4) begin
            errors++;
            $display("[TB] FAIL rstw_followup done cycle=%0d, required 4", doneAt);
        end
    endtask

    task automatic test_wrap_and_badlen();
        logic [31:0] expA;
        poke(32'hFFFFFFFE, 8'hAA);
        poke(32'hFFFFFFFF, 8'hBB);
        poke(32'h0, 8'h01);
        poke(32'h1, 8'h02);
        sb.push_back('{isMem: 1'b1, chk: 1'b1, data: 32'h0201BBAA});
        startMem(1'b0, 32'hFFFFFFFE, 32'h0, 3'd4);
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            expA = 32'hFFFFFFFE + 32'(c - 1);
            checks++;
            if (c <= 4 && ramA !== expA) begin
                errors++;
                $display("[TB] FAIL wrap_addr c=%0d a=%h, required %h", c, ramA, expA);
            end
            checks++;
            if (mcDataE !== (c == 6)) begin
                errors++;
                $display("[TB] FAIL wrap_done c=%0d dataE=%0b, required %0b", c, mcDataE, c == 6);
            end
            nextCycle();
        end
        memMce  = 1'b1;
        memRw   = 1'b0;
        memAddr = 32'h50;
        memLen  = 3'd3;
        for (int c = 0; c < 4; c++) begin
            nextCycle();
            @(negedge clk);
            checks++;
            if (busyMem !== 1'b0 || busyIf !== 1'b0 || mcDataE !== 1'b0) begin
                errors++;
                $display("[TB] FAIL badlen bMem=%0b bIf=%0b mcE=%0b, required 0 0 0", busyMem, busyIf, mcDataE);
            end
        end
        nextCycle();
        memMce = 1'b0;
        nextCycle();
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        ifMce    = 1'b0;
        ifAddr   = 32'h0;
        ifAbort  = 1'b0;
        memMce   = 1'b0;
        memRw    = 1'b0;
        memAddr  = 32'h0;
        memData  = 32'h0;
        memLen   = 3'd0;
        pokeEn   = 1'b0;
        pokeAddr = 16'h0;
        pokeData = 8'h0;
        #1;
        test_reset();
        test_load_word();
        test_store_half();
        test_simultaneous();
        test_abort();
        test_reset_mid_write();
        test_wrap_and_badlen();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL sb_leftover pending=%0d, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
